router_rd_port: RTL and testbench

ROUTER_RD_PORT -- requirements
Module: router_rd_port

---
 rtl/router_rd_port.sv | 191 +++++++++++++++++++
 tb/tb_router_rd_port.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_rd_port.sv
// Router read port: pulls packet bytes from a FIFO and presents them one at a time to a destination.
// Optional macro RD_PORT_PARITY_CHK_EN enables the running-XOR parity check that drives parity_err.
module router_rd_port #(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_enb,
  input  logic       dest_ready,
  output logic       vld_out,
  output logic [7:0] data_out,
  output logic       sop,
  output logic       eop,
  output logic       parity_err,
  output logic       soft_reset,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    LATCH   = 3'd2,
    PRESENT = 3'd3,
    ABORT   = 3'd4
  } state_t;

  // Abort fires on the edge where the stall count would reach TIMEOUT.
  localparam logic [4:0] STALL_LIMIT = 5'(TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [7:0] data_reg, data_next;
  logic       vld_reg, vld_next;
  logic       sop_reg, sop_next;
  logic       eop_reg, eop_next;
  logic       first_reg, first_next;
  logic [6:0] remaining_reg, remaining_next;
  logic [4:0] stall_reg, stall_next;
  logic       rd_enb;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      data_reg      <= 8'h00;
      vld_reg       <= 1'b0;
      sop_reg       <= 1'b0;
      eop_reg       <= 1'b0;
      first_reg     <= 1'b1;
      remaining_reg <= 7'd0;
      stall_reg     <= 5'd0;
    end else begin
      state_reg     <= state_next;
      data_reg      <= data_next;
      vld_reg       <= vld_next;
      sop_reg       <= sop_next;
      eop_reg       <= eop_next;
      first_reg     <= first_next;
      remaining_reg <= remaining_next;
      stall_reg     <= stall_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    data_next      = data_reg;
    vld_next       = vld_reg;
    sop_next       = sop_reg;
    eop_next       = eop_reg;
    first_next     = first_reg;
    remaining_next = remaining_reg;
    stall_next     = stall_reg;
    rd_enb         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = RD;
        end
      end

      RD: begin
        rd_enb = !fifo_empty;
        if (!fifo_empty) begin
          state_next = LATCH;
        end
      end

      LATCH: begin
        // The header is recognised by position; eop comes from the remaining count.
        data_next  = fifo_data;
        vld_next   = 1'b1;
        sop_next   = first_reg;
        eop_next   = !first_reg && (remaining_reg == 7'd1);
        stall_next = 5'd0;
        state_next = PRESENT;
      end

      PRESENT: begin
        if (dest_ready) begin
          vld_next   = 1'b0;
          sop_next   = 1'b0;
          eop_next   = 1'b0;
          stall_next = 5'd0;
          if (sop_reg) begin
            remaining_next = {1'b0, data_reg[7:2]} + 7'd1;
            first_next     = 1'b0;
          end else begin
            remaining_next = remaining_reg - 7'd1;
          end
          if (eop_reg) begin
            first_next     = 1'b1;
            remaining_next = 7'd0;
            state_next     = IDLE;
          end else begin
            state_next = RD;
          end
        end else if (stall_reg == STALL_LIMIT) begin
          vld_next       = 1'b0;
          sop_next       = 1'b0;
          eop_next       = 1'b0;
          stall_next     = 5'd0;
          remaining_next = 7'd0;
          first_next     = 1'b1;
          state_next     = ABORT;
        end else if (stall_reg != 5'h1f) begin
          stall_next = stall_reg + 5'd1;
        end
      end

      ABORT: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef RD_PORT_PARITY_CHK_EN
  logic [7:0] parity_reg, parity_next;
  logic       perr_reg, perr_next;
  logic       accept;
  logic       abort_go;

  // vld_out is always high in PRESENT, so acceptance reduces to dest_ready there.
  assign accept   = (state_reg == PRESENT) && dest_ready;
  assign abort_go = (state_reg == PRESENT) && !dest_ready && (stall_reg == STALL_LIMIT);

  always_comb begin
    parity_next = parity_reg;
    perr_next   = 1'b0;
    if (abort_go) begin
      parity_next = 8'h00;
    end else if (accept) begin
      if (sop_reg) begin
        parity_next = data_reg;
      end else if (eop_reg) begin
        perr_next   = (data_reg != parity_reg);
        parity_next = 8'h00;
      end else begin
        parity_next = parity_reg ^ data_reg;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      parity_reg <= 8'h00;
      perr_reg   <= 1'b0;
    end else begin
      parity_reg <= parity_next;
      perr_reg   <= perr_next;
    end
  end

  assign parity_err = perr_reg;
`else
  assign parity_err = 1'b0;
`endif

  assign fifo_rd_enb = rd_enb;
  assign vld_out     = vld_reg;
  assign data_out    = data_reg;
  assign sop         = sop_reg;
  assign eop         = eop_reg;
  assign soft_reset  = (state_reg == ABORT);
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_router_rd_port.sv
// Scoreboard bench for router_rd_port: a queue-based FIFO model feeds packets, expected bytes are
// queued on load and popped on each accepted output byte.
module tb_router_rd_port;

  logic       clock = 1'b0;
  logic       resetn;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_enb;
  logic       dest_ready;
  logic       vld_out;
  logic [7:0] data_out;
  logic       sop;
  logic       eop;
  logic       parity_err;
  logic       soft_reset;
  logic       busy;

`ifdef RD_PORT_PARITY_CHK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       bad;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] pend_q[$];
  logic [7:0] pkt[$];

  int   checks;
  int   errors;
  int   cycle;
  int   rd_cnt;
  int   acc_cnt;
  int   busy_cycles;
  int   perr_cnt;
  int   vld_rise;
  int   soft_cycle;
  logic vld_prev;
  logic vld_at_soft;
  logic perr_pending;

  router_rd_port #(.TIMEOUT(30)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_enb(fifo_rd_enb),
    .dest_ready (dest_ready),
    .vld_out    (vld_out),
    .data_out   (data_out),
    .sop        (sop),
    .eop        (eop),
    .parity_err (parity_err),
    .soft_reset (soft_reset),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Runs at the falling edge, where every DUT output is stable.
  task automatic monitor();
    exp_t e;
    logic perr_now;
    perr_now     = perr_pending;
    perr_pending = 1'b0;
    check("rd_while_empty", 32'(fifo_rd_enb & fifo_empty), 0);
    check("parity_err", 32'(parity_err), 32'(perr_now));
    if (parity_err) perr_cnt++;
    if (fifo_rd_enb) rd_cnt++;
    if (busy) busy_cycles++;
    if (vld_out && !vld_prev) vld_rise = cycle;
    vld_prev = vld_out;
    if (soft_reset) begin
      soft_cycle  = cycle;
      vld_at_soft = vld_out;
    end
    if (resetn && vld_out && dest_ready) begin
      acc_cnt++;
      $display("OUT cycle=%0d data=%02h sop=%0b eop=%0b", cycle, data_out, sop, eop);
      if (exp_q.size() == 0) begin
        check("spurious_byte", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("data", 32'(data_out), 32'(e.data));
        check("sop", 32'(sop), 32'(e.sop));
        check("eop", 32'(eop), 32'(e.eop));
        if (e.eop) perr_pending = e.bad & PCHK;
      end
    end
  endtask

  // One clock: monitor at the falling edge, FIFO model and stimulus updated just after the rising edge.
  task automatic tick();
    logic do_pop;
    logic do_flush;
    @(negedge clock);
    monitor();
    do_pop   = fifo_rd_enb;
    do_flush = soft_reset;
    @(posedge clock);
    #1;
    if (do_pop && fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
    if (do_flush) fifo_q.delete();
    fifo_empty = (fifo_q.size() == 0);
    cycle++;
  endtask

  task automatic load_pkt();
    logic [7:0] x;
    exp_t e;
    x = 8'h00;
    for (int i = 0; i < pkt.size(); i++) begin
      e.data = pkt[i];
      e.sop  = (i == 0);
      e.eop  = (i == pkt.size() - 1);
      e.bad  = e.eop && (pkt[i] != x);
      if (!e.eop) x = x ^ pkt[i];
      exp_q.push_back(e);
      pend_q.push_back(pkt[i]);
    end
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n && pend_q.size() != 0; i++) fifo_q.push_back(pend_q.pop_front());
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic start();
    rd_cnt      = 0;
    acc_cnt     = 0;
    busy_cycles = 0;
    perr_cnt    = 0;
  endtask

  task automatic drain(input string tag, input bit rand_ready, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      if (rand_ready) dest_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    dest_ready = 1'b1;
    check({tag, "_left"}, 32'(exp_q.size()), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    repeat (2) tick();
  endtask

  task automatic wait_acc(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (acc_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, acc_cnt, target);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_vld"}, 32'(vld_out), 0);
    check({tag, "_sop"}, 32'(sop), 0);
    check({tag, "_eop"}, 32'(eop), 0);
    check({tag, "_perr"}, 32'(parity_err), 0);
    check({tag, "_soft"}, 32'(soft_reset), 0);
    check({tag, "_rd"}, 32'(fifo_rd_enb), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_data"}, 32'(data_out), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] x;
    logic [7:0] b;
    int n;
    checks = 0; errors = 0; cycle = 0;
    rd_cnt = 0; acc_cnt = 0; busy_cycles = 0; perr_cnt = 0;
    vld_rise = -1; soft_cycle = -1; vld_prev = 1'b0; vld_at_soft = 1'b0; perr_pending = 1'b0;
    resetn = 1'b0; dest_ready = 1'b0; fifo_empty = 1'b1; fifo_data = 8'h00;
    repeat (3) tick();
    check_idle("reset");
    resetn = 1'b1;
    tick();

    // Good-parity packet, destination always ready.
    start();
    dest_ready = 1'b1;
    pkt = {8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
    load_pkt(); feed(5);
    drain("basic", 1'b0, 200);
    check("basic_busy_cycles", busy_cycles, 15);
    check("basic_reads", rd_cnt, 5);
    check("basic_bytes", acc_cnt, 5);
    check("basic_perr_cnt", perr_cnt, 0);

    // Same packet with a corrupted parity byte.
    start();
    pkt = {8'h0C, 8'h11, 8'h22, 8'h33, 8'h0D};
    load_pkt(); feed(5);
    drain("badpar", 1'b0, 200);
    check("badpar_perr_cnt", perr_cnt, PCHK ? 1 : 0);

    // Zero-length header: header plus parity only, then no further reads.
    start();
    pkt = {8'h00, 8'h00};
    load_pkt(); feed(2);
    drain("zero_len", 1'b0, 100);
    repeat (5) tick();
    check("zero_len_reads", rd_cnt, 2);
    check("zero_len_bytes", acc_cnt, 2);

    // Longest packet (63 payload bytes) with random back-pressure.
    start();
    pkt.delete();
    pkt.push_back(8'hFC);
    x = 8'hFC;
    for (int i = 0; i < 63; i++) begin
      b = 8'($urandom_range(0, 255));
      pkt.push_back(b);
      x = x ^ b;
    end
    pkt.push_back(x);
    load_pkt(); feed(65);
    drain("long", 1'b1, 3000);
    check("long_reads", rd_cnt, 65);
    check("long_perr_cnt", perr_cnt, 0);

    // Mid-packet underflow: FIFO runs dry after two bytes of a four-byte packet.
    start();
    pkt = {8'h08, 8'hA1, 8'hB2, 8'h1B};
    load_pkt(); feed(2);
    wait_acc("underflow_first_two", 2, 50);
    repeat (10) begin
      tick();
      check("underflow_busy", 32'(busy), 1);
      check("underflow_vld", 32'(vld_out), 0);
    end
    check("underflow_reads_held", rd_cnt, 2);
    feed(2);
    drain("underflow", 1'b0, 200);
    check("underflow_reads", rd_cnt, 4);

    // Destination stalls after the header until the timeout abort.
    start();
    dest_ready = 1'b0;
    vld_rise = -1; soft_cycle = -1;
    pkt = {8'h04, 8'h55, 8'h51};
    load_pkt(); feed(3);
    n = 0;
    while (soft_cycle < 0 && n < 200) begin
      tick();
      n++;
    end
    check("abort_delay", soft_cycle - vld_rise, 30);
    check("abort_vld_at_pulse", 32'(vld_at_soft), 0);
    check("abort_vld_after", 32'(vld_out), 0);
    check("abort_soft_width", 32'(soft_reset), 0);
    check("abort_idle", 32'(busy), 0);
    exp_q.delete(); pend_q.delete();
    dest_ready = 1'b1;
    repeat (5) tick();
    check("abort_reads", rd_cnt, 1);
    check("abort_bytes", acc_cnt, 0);

    // Reset pulse during the payload; next byte must start a fresh packet.
    start();
    pkt = {8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
    load_pkt(); feed(5);
    wait_acc("midrst_first_two", 2, 100);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    fifo_q.delete(); exp_q.delete(); pend_q.delete();
    fifo_empty = 1'b1;
    check_idle("midrst");
    tick();
    start();
    pkt = {8'h04, 8'hAA, 8'hAE};
    load_pkt(); feed(3);
    drain("after_rst", 1'b0, 200);
    check("after_rst_reads", rd_cnt, 3);
    check("after_rst_perr_cnt", perr_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
